// File: rtl/iob_cache_req_arbiter.sv
// N-port request arbiter sharing one cache IOb front-end; strictly one outstanding transaction.
// Define IOB_CACHE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module iob_cache_req_arbiter #(
  parameter int unsigned N_PORTS  = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned USE_CTRL = 0,
  localparam int unsigned AW      = USE_CTRL + ADDR_W,
  localparam int unsigned SW      = DATA_W / 8,
  localparam int unsigned GW      = $clog2(N_PORTS)
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic [N_PORTS-1:0]    s_avalid_i,
  input  logic [N_PORTS*AW-1:0] s_addr_i,
  input  logic [N_PORTS*DATA_W-1:0] s_wdata_i,
  input  logic [N_PORTS*SW-1:0] s_wstrb_i,
  output logic [N_PORTS*DATA_W-1:0] s_rdata_o,
  output logic [N_PORTS-1:0]    s_rvalid_o,
  output logic [N_PORTS-1:0]    s_ready_o,
  output logic                  m_avalid_o,
  output logic [AW-1:0]         m_addr_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [SW-1:0]         m_wstrb_o,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic                  m_rvalid_i,
  input  logic                  m_ready_i,
  output logic [GW-1:0]         grant_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              we_q, we_d;

  logic              win_found;
  logic [GW-1:0]     win_idx;

  // Winner search; iterating in reverse lets the highest-priority candidate be assigned last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (s_avalid_i[i]) begin
        win_found = 1'b1;
        win_idx   = GW'(i);
      end
    end
`else
    for (int off = N_PORTS; off >= 1; off--) begin
      if (s_avalid_i[(int'(grant_q) + off) % int'(N_PORTS)]) begin
        win_found = 1'b1;
        win_idx   = GW'((int'(grant_q) + off) % int'(N_PORTS));
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    s_ready_o  = '0;
    s_rvalid_o = '0;
    // Handshake outputs are gated by cke_i so a frozen cycle neither accepts nor responds.
    if (cke_i) begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            s_ready_o[win_idx] = 1'b1;
            addr_d             = s_addr_i[int'(win_idx)*AW +: AW];
            wdata_d            = s_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
            wstrb_d            = s_wstrb_i[int'(win_idx)*SW +: SW];
            we_d               = |s_wstrb_i[int'(win_idx)*SW +: SW];
            grant_d            = win_idx;
            state_d            = StIssue;
          end
        end
        StIssue: begin
          if (m_ready_i) state_d = StWait;
        end
        StWait: begin
          if (m_ready_i) begin
            state_d             = StIdle;
            s_rvalid_o[grant_q] = m_rvalid_i & ~we_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      grant_q <= GW'(N_PORTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
    end
  end

  assign m_avalid_o = (state_q == StIssue);
  assign m_addr_o   = addr_q;
  assign m_wdata_o  = wdata_q;
  assign m_wstrb_o  = wstrb_q;
  assign s_rdata_o  = {N_PORTS{m_rdata_i}};
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_iob_cache_req_arbiter.sv
// Directed bench for iob_cache_req_arbiter (4 ports, 32-bit address/data, no ctrl bit).
module tb_iob_cache_req_arbiter;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         cke;
  logic [3:0]   s_avalid;
  logic [127:0] s_addr;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_rvalid;
  logic [3:0]   s_ready;
  logic         m_avalid;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_rdata;
  logic         m_rvalid;
  logic         m_ready;
  logic [1:0]   grant;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  iob_cache_req_arbiter #(
    .N_PORTS (4),
    .ADDR_W  (32),
    .DATA_W  (32),
    .USE_CTRL(0)
  ) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .cke_i     (cke),
    .s_avalid_i(s_avalid),
    .s_addr_i  (s_addr),
    .s_wdata_i (s_wdata),
    .s_wstrb_i (s_wstrb),
    .s_rdata_o (s_rdata),
    .s_rvalid_o(s_rvalid),
    .s_ready_o (s_ready),
    .m_avalid_o(m_avalid),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_wstrb_o (m_wstrb),
    .m_rdata_i (m_rdata),
    .m_rvalid_i(m_rvalid),
    .m_ready_i (m_ready),
    .grant_o   (grant),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st);
    s_avalid[p]       = 1'b1;
    s_addr[p*32 +: 32]  = a;
    s_wdata[p*32 +: 32] = d;
    s_wstrb[p*4 +: 4]   = st;
  endtask

  task automatic do_reset();
    arst_n   = 1'b0;
    cke      = 1'b1;
    s_avalid = '0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ready  = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    checks++;
    if ({m_avalid, busy, s_ready, s_rvalid} !== 10'b0) begin
      $display("FAIL reset_ctl: got %b want 0", {m_avalid, busy, s_ready, s_rvalid}); fails++;
    end
    checks++;
    if ({m_addr, m_wdata, m_wstrb} !== 68'b0) begin
      $display("FAIL reset_m: got %h want 0", {m_addr, m_wdata, m_wstrb}); fails++;
    end
    checks++;
    if (grant !== 2'd3) begin $display("FAIL reset_grant: got %0d want 3", grant); fails++; end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    set_req(1, 32'h40, 32'h0, 4'h0);
    #1;
    checks++;
    if (s_ready !== 4'b0010) begin $display("FAIL rd_ready: got %b want 0010", s_ready); fails++; end
    @(negedge clk);
    s_avalid = '0;
    m_ready  = 1'b1;
    #1;
    checks++;
    if (m_avalid !== 1'b1 || m_addr !== 32'h40 || grant !== 2'd1 || s_ready !== 4'b0) begin
      $display("FAIL rd_issue: got av=%b a=%h g=%0d r=%b want 1 40 1 0000",
               m_avalid, m_addr, grant, s_ready); fails++;
    end
    @(negedge clk);
    m_rvalid = 1'b1;
    m_rdata  = 32'hCAFEBABE;
    #1;
    checks++;
    if (s_rvalid !== 4'b0010 || s_rdata[63:32] !== 32'hCAFEBABE || m_avalid !== 1'b0) begin
      $display("FAIL rd_resp: got rv=%b d=%h av=%b want 0010 cafebabe 0",
               s_rvalid, s_rdata[63:32], m_avalid); fails++;
    end
    @(negedge clk);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || s_rvalid !== 4'b0) begin
      $display("FAIL rd_done: got busy=%b rv=%b want 0 0000", busy, s_rvalid); fails++;
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    set_req(2, 32'h80, 32'h11223344, 4'hF);
    #1;
    checks++;
    if (s_ready !== 4'b0100) begin $display("FAIL wr_ready: got %b want 0100", s_ready); fails++; end
    @(negedge clk);
    s_avalid = '0;
    m_ready  = 1'b1;
    #1;
    checks++;
    if (m_wstrb !== 4'hF || m_wdata !== 32'h11223344 || m_addr !== 32'h80) begin
      $display("FAIL wr_issue: got s=%h d=%h a=%h want f 11223344 80", m_wstrb, m_wdata, m_addr);
      fails++;
    end
    @(negedge clk);
    m_rvalid = 1'b1;
    #1;
    checks++;
    if (s_rvalid !== 4'b0) begin $display("FAIL wr_norv: got %b want 0000", s_rvalid); fails++; end
    @(negedge clk);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin $display("FAIL wr_idle: got busy=%b want 0", busy); fails++; end
  endtask

  task automatic test_contention();
    int exp_order[5];
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int p = 0; p < 4; p++) set_req(p, 32'h10 * p, 32'h0, 4'h0);
    m_ready  = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'hA5A50000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (s_ready !== (4'b1 << exp_order[k])) begin
        $display("FAIL cont_ready[%0d]: got %b want port %0d", k, s_ready, exp_order[k]); fails++;
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_addr !== 32'h10 * exp_order[k] || grant !== 2'(exp_order[k])) begin
        $display("FAIL cont_issue[%0d]: got a=%h g=%0d want port %0d", k, m_addr, grant,
                 exp_order[k]); fails++;
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_rvalid !== (4'b1 << exp_order[k])) begin
        $display("FAIL cont_rvalid[%0d]: got %b want port %0d", k, s_rvalid, exp_order[k]);
        fails++;
      end
      @(negedge clk);
    end
    s_avalid = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    set_req(3, 32'h123, 32'h0, 4'h0);
    #1;
    checks++;
    if (s_ready !== 4'b1000) begin $display("FAIL bp_ready: got %b want 1000", s_ready); fails++; end
    @(negedge clk);
    s_avalid = '0;
    set_req(0, 32'h200, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (m_avalid !== 1'b1 || m_addr !== 32'h123 || s_ready !== 4'b0) begin
        $display("FAIL bp_issue[%0d]: got av=%b a=%h r=%b want 1 123 0000",
                 c, m_avalid, m_addr, s_ready); fails++;
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || m_avalid !== 1'b0 || s_ready !== 4'b0 || s_rvalid !== 4'b0) begin
        $display("FAIL bp_wait[%0d]: got busy=%b av=%b r=%b rv=%b want 1 0 0000 0000",
                 c, busy, m_avalid, s_ready, s_rvalid); fails++;
      end
      @(negedge clk);
    end
    m_ready  = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'hDEADBEEF;
    #1;
    checks++;
    if (s_rvalid !== 4'b1000 || s_rdata[127:96] !== 32'hDEADBEEF) begin
      $display("FAIL bp_resp: got rv=%b d=%h want 1000 deadbeef", s_rvalid, s_rdata[127:96]);
      fails++;
    end
    @(negedge clk);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 4'b0001) begin $display("FAIL bp_next: got %b want 0001", s_ready); fails++; end
    @(negedge clk);
    s_avalid = '0;
    m_ready  = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    m_rvalid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || m_avalid !== 1'b0) begin
      $display("FAIL rst_pre: got busy=%b av=%b want 1 0", busy, m_avalid); fails++;
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({m_avalid, busy, s_ready, s_rvalid} !== 10'b0 || m_addr !== 32'h0) begin
      $display("FAIL rst_mid: got ctl=%b a=%h want 0 0", {m_avalid, busy, s_ready, s_rvalid},
               m_addr); fails++;
    end
    checks++;
    if (grant !== 2'd3) begin $display("FAIL rst_grant: got %0d want 3", grant); fails++; end
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    set_req(1, 32'h300, 32'h0, 4'h0);
    set_req(0, 32'h200, 32'h0, 4'h0);
    #1;
    checks++;
    if (s_ready !== 4'b0001) begin $display("FAIL rst_first: got %b want 0001", s_ready); fails++; end
    @(negedge clk);
    s_avalid[0] = 1'b0;
  endtask

  task automatic test_cke();
    cke     = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (m_avalid !== 1'b1 || m_addr !== 32'h200 || grant !== 2'd0 || s_ready !== 4'b0 ||
          busy !== 1'b1) begin
        $display("FAIL cke_hold[%0d]: got av=%b a=%h g=%0d r=%b busy=%b want 1 200 0 0000 1",
                 c, m_avalid, m_addr, grant, s_ready, busy); fails++;
      end
      @(negedge clk);
    end
    cke = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b1;
    m_rdata  = 32'h0BADF00D;
    #1;
    checks++;
    if (s_rvalid !== 4'b0001 || s_rdata[31:0] !== 32'h0BADF00D) begin
      $display("FAIL cke_resp: got rv=%b d=%h want 0001 0badf00d", s_rvalid, s_rdata[31:0]);
      fails++;
    end
    @(negedge clk);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 4'b0010) begin $display("FAIL cke_next: got %b want 0010", s_ready); fails++; end
    @(negedge clk);
    s_avalid = '0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
    test_cke();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
